// File: rtl/sdram_pkg.sv
// Shared widths and arbiter state encoding for the SDRAM client arbiter.
package sdram_pkg;

   localparam int SDRAM_AW = 20;
   localparam int SDRAM_DW = 16;
   localparam int SDRAM_LW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } arb_state_t;

   // Width of a client index; a single bit is kept even for degenerate counts.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational winner selection among requesting clients.
// Round-robin from last+1 by default; SDRAM_ARB_FIXED_PRIO_EN selects lowest-index-wins.
module rr_pick
   import sdram_pkg::*;
#(
   parameter int N = 3,
   localparam int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] idx
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = ^last;

   // Scan from the top so the lowest requesting index is written last and wins.
   always_comb begin
      pick = '0;
      idx  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            pick    = '0;
            pick[i] = 1'b1;
            idx     = IW'(i);
         end
      end
   end
`else
   // Scan offsets from farthest to nearest so the first requester after last wins.
   always_comb begin
      pick = '0;
      idx  = '0;
      for (int k = N; k >= 1; k--) begin
         if (req[(int'(last) + k) % N]) begin
            pick                         = '0;
            pick[(int'(last) + k) % N]   = 1'b1;
            idx                          = IW'((int'(last) + k) % N);
         end
      end
   end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Grants one client a whole read or write burst on the shared SDRAM controller port.
// Optional macro SDRAM_ARB_FIXED_PRIO_EN switches round-robin to fixed lowest-index priority.
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int NCLIENTS = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NCLIENTS*SDRAM_AW-1:0] cl_rd_addr,
   input  logic [NCLIENTS*SDRAM_LW-1:0] cl_rd_len,
   input  logic [NCLIENTS-1:0]          cl_rd_req,
   output logic [NCLIENTS-1:0]          cl_rd_ack,
   output logic [NCLIENTS-1:0]          cl_rd_rdy,
   output logic [SDRAM_DW-1:0]          cl_rd_data,
   input  logic [NCLIENTS*SDRAM_AW-1:0] cl_wr_addr,
   input  logic [NCLIENTS*SDRAM_DW-1:0] cl_wr_data,
   input  logic [NCLIENTS*SDRAM_LW-1:0] cl_wr_len,
   input  logic [NCLIENTS-1:0]          cl_wr_req,
   output logic [NCLIENTS-1:0]          cl_wr_ack,
   output logic [SDRAM_AW-1:0]          mem_rd_addr,
   output logic [SDRAM_LW-1:0]          mem_rd_len,
   output logic                         mem_rd_req,
   input  logic                         mem_rd_ack,
   input  logic [SDRAM_DW-1:0]          mem_rd_data,
   input  logic                         mem_rd_rdy,
   output logic [SDRAM_AW-1:0]          mem_wr_addr,
   output logic [SDRAM_DW-1:0]          mem_wr_data,
   output logic [SDRAM_LW-1:0]          mem_wr_len,
   output logic                         mem_wr_req,
   input  logic                         mem_wr_ack,
   output logic [NCLIENTS-1:0]          grant
);

   localparam int IW = idx_width(NCLIENTS);

   arb_state_t          state, state_nxt;
   logic [IW-1:0]       gidx, gidx_nxt, last, last_nxt, pick_idx;
   logic [NCLIENTS-1:0] grant_nxt, pick, any_req;
   logic                acked, acked_nxt, done;
   logic [4:0]          cnt, cnt_nxt;

   assign any_req = cl_rd_req | cl_wr_req;

   rr_pick #(.N(NCLIENTS)) u_pick (
      .req  (any_req),
      .last (last),
      .pick (pick),
      .idx  (pick_idx)
   );

   assign cl_rd_data  = mem_rd_data;
   assign mem_rd_addr = cl_rd_addr[gidx*SDRAM_AW +: SDRAM_AW];
   assign mem_rd_len  = cl_rd_len[gidx*SDRAM_LW +: SDRAM_LW];
   assign mem_wr_addr = cl_wr_addr[gidx*SDRAM_AW +: SDRAM_AW];
   assign mem_wr_data = cl_wr_data[gidx*SDRAM_DW +: SDRAM_DW];
   assign mem_wr_len  = cl_wr_len[gidx*SDRAM_LW +: SDRAM_LW];

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         grant <= '0;
         gidx  <= '0;
         last  <= IW'(NCLIENTS - 1);
         acked <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         gidx  <= gidx_nxt;
         last  <= last_nxt;
         acked <= acked_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // In IDLE the winner is registered; in RD/WR strobes pass straight through to the owner.
   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      gidx_nxt   = gidx;
      last_nxt   = last;
      acked_nxt  = acked;
      cnt_nxt    = cnt;
      done       = 1'b0;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      cl_rd_ack  = '0;
      cl_rd_rdy  = '0;
      cl_wr_ack  = '0;
      unique case (state)
         IDLE: begin
            if (|any_req) begin
               grant_nxt = pick;
               gidx_nxt  = pick_idx;
               last_nxt  = pick_idx;
               acked_nxt = 1'b0;
               if (cl_rd_req[pick_idx]) begin
                  state_nxt = RD;
                  cnt_nxt   = {1'b0, cl_rd_len[pick_idx*SDRAM_LW +: SDRAM_LW]} + 5'd1;
               end else begin
                  state_nxt = WR;
                  cnt_nxt   = {1'b0, cl_wr_len[pick_idx*SDRAM_LW +: SDRAM_LW]} + 5'd1;
               end
            end
         end
         RD: begin
            mem_rd_req = cl_rd_req[gidx] & ~acked;
            if (mem_rd_req && mem_rd_ack) begin
               cl_rd_ack[gidx] = 1'b1;
               acked_nxt       = 1'b1;
            end
            if (mem_rd_rdy) begin
               cl_rd_rdy[gidx] = 1'b1;
               cnt_nxt         = cnt - 5'd1;
               if (cnt == 5'd1) done = 1'b1;
            end
            if (!cl_rd_req[gidx] && !acked) done = 1'b1;
         end
         WR: begin
            mem_wr_req = cl_wr_req[gidx];
            if (mem_wr_req && mem_wr_ack) begin
               cl_wr_ack[gidx] = 1'b1;
               acked_nxt       = 1'b1;
               cnt_nxt         = cnt - 5'd1;
               if (cnt == 5'd1) done = 1'b1;
            end else if (!cl_wr_req[gidx] && !acked) begin
               done = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (done) begin
         state_nxt = IDLE;
         grant_nxt = '0;
         acked_nxt = 1'b0;
         cnt_nxt   = '0;
      end
   end

endmodule
